// File: rtl/mmio_led_pkg.sv
// Shared definitions for the memory-mapped LED controller: register word
// offsets (memAddress[4:2]) and PWM constants. The PWM dimming feature is
// compiled in only when the LEDS_PWM_EN macro is defined.
package mmio_led_pkg;

    // Word offsets within the register window.
    typedef enum logic [2:0] {
        OFF_VALUE        = 3'd0,
        OFF_SET          = 3'd1,
        OFF_CLR          = 3'd2,
        OFF_BLINK_MASK   = 3'd3,
        OFF_BLINK_PERIOD = 3'd4,
        OFF_PWM_DUTY     = 3'd5,
        OFF_RSVD_6       = 3'd6,
        OFF_RSVD_7       = 3'd7
    } reg_off_e;

    localparam int             PWM_W        = 8;
    localparam logic [PWM_W-1:0] PWM_DUTY_RST = 8'hFF;

endpackage

// File: rtl/led_blink_timer.sv
// Blink phase generator. With a zero period the phase is held high so that
// blinking LEDs stay steadily on; otherwise each phase lasts exactly `period`
// clocks. A restart pulse (BLINK_PERIOD write) re-aligns the counter so the
// next phase is a full "on" phase.
module led_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] bcnt_q, bcnt_d;
    logic                phase_q, phase_d;

    // Next counter/phase value: hold, restart, count, or wrap-and-toggle.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (restart || (period == '0)) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (bcnt_q == (period - ONE)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + ONE;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED output controller: VALUE register with atomic SET/CLR,
// per-LED hardware blinking, registered readback and registered LED outputs.
// Optional global PWM dimming is enabled by defining LEDS_PWM_EN; without it
// the PWM_DUTY offset behaves as a reserved location.
module mmio_led_ctrl
    import mmio_led_pkg::*;
#(
    parameter int NUM_LEDS = 16,
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         writeData,
    input  logic                writeEnable,
    input  logic                readEnable,
    input  logic [31:0]         memAddress,
    output logic [31:0]         readData,
    output logic [NUM_LEDS-1:0] leds
);

    reg_off_e off;
    assign off = reg_off_e'(memAddress[4:2]);

    // Address bits outside the window and write-data bits above the widest
    // register are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{memAddress[31:5], memAddress[1:0], writeData};

    logic [NUM_LEDS-1:0] value_q, value_d;
    logic [NUM_LEDS-1:0] mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                restart;
    logic                phase;
    logic                pwm_on;

`ifdef LEDS_PWM_EN
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [PWM_W-1:0] pcnt_q, pcnt_d;
`endif

    // Register-file write decode; narrower registers drop the upper data bits.
    always_comb begin
        value_d  = value_q;
        mask_d   = mask_q;
        period_d = period_q;
        restart  = 1'b0;
`ifdef LEDS_PWM_EN
        duty_d   = duty_q;
`endif
        if (writeEnable) begin
            case (off)
                OFF_VALUE:        value_d  = writeData[NUM_LEDS-1:0];
                OFF_SET:          value_d  = value_q | writeData[NUM_LEDS-1:0];
                OFF_CLR:          value_d  = value_q & ~writeData[NUM_LEDS-1:0];
                OFF_BLINK_MASK:   mask_d   = writeData[NUM_LEDS-1:0];
                OFF_BLINK_PERIOD: begin
                    period_d = writeData[PERIOD_W-1:0];
                    restart  = 1'b1;
                end
`ifdef LEDS_PWM_EN
                OFF_PWM_DUTY:     duty_d   = writeData[PWM_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Read mux: load zero-extended register contents on a read strobe, else hold.
    always_comb begin
        rdata_d = rdata_q;
        if (readEnable) begin
            rdata_d = '0;
            case (off)
                OFF_VALUE:        rdata_d[NUM_LEDS-1:0] = value_q;
                OFF_BLINK_MASK:   rdata_d[NUM_LEDS-1:0] = mask_q;
                OFF_BLINK_PERIOD: rdata_d[PERIOD_W-1:0] = period_q;
`ifdef LEDS_PWM_EN
                OFF_PWM_DUTY:     rdata_d[PWM_W-1:0]    = duty_q;
`endif
                default: ;
            endcase
        end
    end

    led_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink (
        .clk     (clk),
        .rst_n   (rst_n),
        .period  (period_q),
        .restart (restart),
        .phase   (phase)
    );

`ifdef LEDS_PWM_EN
    // Free-running PWM counter and duty compare; 0xFF forces fully on.
    always_comb begin
        pcnt_d = pcnt_q + PWM_W'(1);
        pwm_on = (duty_q == PWM_DUTY_RST) | (pcnt_q < duty_q);
    end

    // PWM duty register and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= PWM_DUTY_RST;
            pcnt_q <= '0;
        end else begin
            duty_q <= duty_d;
            pcnt_q <= pcnt_d;
        end
    end
`else
    assign pwm_on = 1'b1;
`endif

    // LED output function: blinking LEDs are forced off in the low phase.
    always_comb begin
        leds_d = value_q & ~(mask_q & {NUM_LEDS{~phase}}) & {NUM_LEDS{pwm_on}};
    end

    // Register file, read data and output pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= '0;
            mask_q   <= '0;
            period_q <= '0;
            leds_q   <= '0;
            rdata_q  <= '0;
        end else begin
            value_q  <= value_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            leds_q   <= leds_d;
            rdata_q  <= rdata_d;
        end
    end

    assign readData = rdata_q;
    assign leds     = leds_q;

endmodule
